// File: rtl/aurora_link_ctrl.sv
// Aurora link supervisor: sequences the core reset, waits for channel_up, and
// retries with backoff on timeouts, hard errors or excessive soft errors.
module aurora_link_ctrl #(
  parameter int unsigned RESET_CYCLES   = 16,
  parameter int unsigned UP_TIMEOUT     = 1024,
  parameter int unsigned BACKOFF_CYCLES = 64,
  parameter int unsigned SOFT_ERR_LIMIT = 8,
  parameter int unsigned WINDOW_CYCLES  = 4096
) (
  input  logic        user_clk,
  input  logic        aresetn,
  input  logic        enable,
  input  logic        clr_counts,
  input  logic        channel_up,
  input  logic        hard_err,
  input  logic        soft_err,
  output logic        ext_reset,
  output logic        link_ok,
  output logic [2:0]  state,
  output logic [7:0]  retry_count,
  output logic [15:0] soft_err_total
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RESET   = 3'd1;
  localparam logic [2:0] ST_WAIT_UP = 3'd2;
  localparam logic [2:0] ST_UP      = 3'd3;
  localparam logic [2:0] ST_BACKOFF = 3'd4;

  localparam logic [15:0] RC_LAST  = 16'(RESET_CYCLES - 1);
  localparam logic [15:0] UT_LAST  = 16'(UP_TIMEOUT - 1);
  localparam logic [15:0] BC_LAST  = 16'(BACKOFF_CYCLES - 1);
  localparam logic [15:0] WIN_LAST = 16'(WINDOW_CYCLES - 1);
  localparam logic [16:0] ERR_LIM  = 17'(SOFT_ERR_LIMIT);

  logic [2:0]  state_r;
  logic [2:0]  next_s;
  logic        retry_s;
  logic        ext_reset_r;
  logic        link_ok_r;
  logic [15:0] timer_r;
  logic [15:0] win_cnt_r;
  logic [15:0] win_err_r;
  logic [16:0] cur_err_s;
  logic [7:0]  retry_count_r;
  logic [15:0] soft_err_total_r;

  assign state          = state_r;
  assign ext_reset      = ext_reset_r;
  assign link_ok        = link_ok_r;
  assign retry_count    = retry_count_r;
  assign soft_err_total = soft_err_total_r;

  // Soft errors in the current window including this cycle; a window starts whenever win_cnt is 0.
  always_comb begin
    cur_err_s = 17'd0;
    if (win_cnt_r == 16'd0) begin
      cur_err_s = {16'd0, soft_err};
    end else begin
      cur_err_s = {1'b0, win_err_r} + {16'd0, soft_err};
    end
  end

  // Next-state decision; enable low overrides every other transition and cancels any retry.
  always_comb begin
    next_s  = state_r;
    retry_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        next_s = ST_RESET;
      end
      ST_RESET: begin
        if (timer_r == RC_LAST) begin
          next_s = ST_WAIT_UP;
        end else begin
          next_s = ST_RESET;
        end
      end
      ST_WAIT_UP: begin
        if (channel_up) begin
          next_s = ST_UP;
        end else if (timer_r == UT_LAST) begin
          next_s  = ST_BACKOFF;
          retry_s = 1'b1;
        end else begin
          next_s = ST_WAIT_UP;
        end
      end
      ST_UP: begin
        if (!channel_up || hard_err || (cur_err_s >= ERR_LIM)) begin
          next_s  = ST_BACKOFF;
          retry_s = 1'b1;
        end else begin
          next_s = ST_UP;
        end
      end
      ST_BACKOFF: begin
        if (timer_r == BC_LAST) begin
          next_s = ST_RESET;
        end else begin
          next_s = ST_BACKOFF;
        end
      end
      default: begin
        next_s = ST_IDLE;
      end
    endcase
    if (!enable) begin
      next_s  = ST_IDLE;
      retry_s = 1'b0;
    end else begin
      next_s  = next_s;
      retry_s = retry_s;
    end
  end

  // State, registered outputs and the per-state timer (restarts from 0 on every state change).
  always_ff @(posedge user_clk or negedge aresetn) begin
    if (!aresetn) begin
      state_r     <= ST_IDLE;
      ext_reset_r <= 1'b1;
      link_ok_r   <= 1'b0;
      timer_r     <= 16'd0;
    end else begin
      state_r     <= next_s;
      ext_reset_r <= (next_s != ST_WAIT_UP) && (next_s != ST_UP);
      link_ok_r   <= (next_s == ST_UP);
      if ((next_s != state_r) || (state_r == ST_IDLE) || (state_r == ST_UP)) begin
        timer_r <= 16'd0;
      end else begin
        timer_r <= timer_r + 16'd1;
      end
    end
  end

  // Soft-error window; held at zero outside UP so every UP entry starts a fresh window.
  always_ff @(posedge user_clk or negedge aresetn) begin
    if (!aresetn) begin
      win_cnt_r <= 16'd0;
      win_err_r <= 16'd0;
    end else if ((state_r == ST_UP) && (next_s == ST_UP)) begin
      win_cnt_r <= (win_cnt_r == WIN_LAST) ? 16'd0 : win_cnt_r + 16'd1;
      win_err_r <= cur_err_s[15:0];
    end else begin
      win_cnt_r <= 16'd0;
      win_err_r <= 16'd0;
    end
  end

  // Saturating statistics; a clear wins over a same-cycle increment.
  always_ff @(posedge user_clk or negedge aresetn) begin
    if (!aresetn) begin
      retry_count_r    <= 8'd0;
      soft_err_total_r <= 16'd0;
    end else if (clr_counts) begin
      retry_count_r    <= 8'd0;
      soft_err_total_r <= 16'd0;
    end else begin
      if (retry_s && (retry_count_r != 8'hFF)) begin
        retry_count_r <= retry_count_r + 8'd1;
      end
      if ((state_r == ST_UP) && soft_err && (soft_err_total_r != 16'hFFFF)) begin
        soft_err_total_r <= soft_err_total_r + 16'd1;
      end
    end
  end

endmodule

// File: doc/aurora_link_ctrl.md
AURORA_LINK_CTRL -- requirements
Module: aurora_link_ctrl

Interface
REQ-001 Parameter RESET_CYCLES, default 16: cycles ext_reset is held high in RESET state.
REQ-002 Parameter UP_TIMEOUT, default 1024: cycles allowed in WAIT_UP before a retry.
REQ-003 Parameter BACKOFF_CYCLES, default 64: cycles held in BACKOFF before re-entering RESET.
REQ-004 Parameter SOFT_ERR_LIMIT, default 8: soft errors per window that force a retry.
REQ-005 Parameter WINDOW_CYCLES, default 4096: soft-error observation window length.
REQ-006 Every parameter is 1..65535, so all timers are 16 bits wide.
REQ-007 Clock and reset: one clock, user_clk; reset is asynchronous and active-low, aresetn.
REQ-008 Port user_clk, input, 1 bit: the only clock.
REQ-009 Port aresetn, input, 1 bit: asynchronous active-low reset.
REQ-010 Port enable, input, 1 bit: link permitted to run when high.
REQ-011 Port clr_counts, input, 1 bit: single-cycle pulse that clears the statistics counters.
REQ-012 Port channel_up, input, 1 bit: Aurora channel status.
REQ-013 Port hard_err, input, 1 bit: Aurora hard-error strobe.
REQ-014 Port soft_err, input, 1 bit: Aurora soft-error strobe.
REQ-015 Port ext_reset, output, 1 bit: registered reset request to the Aurora core wrapper.
REQ-016 Port link_ok, output, 1 bit: registered, high only in state UP.
REQ-017 Port state, output, 3 bits: encoding IDLE=0, RESET=1, WAIT_UP=2, UP=3, BACKOFF=4.
REQ-018 Port retry_count, output, 8 bits: saturating count of link retries.
REQ-019 Port soft_err_total, output, 16 bits: saturating count of soft_err cycles seen in state UP.

Function
REQ-020 All outputs are registered, and every next-state decision takes effect on the following user_clk edge.
REQ-021 enable low in any state forces IDLE on the next cycle; this has priority over every other transition.
REQ-022 IDLE: ext_reset=1, link_ok=0; enable high moves to RESET.
REQ-023 RESET: ext_reset=1 for exactly RESET_CYCLES cycles counted from entry, then WAIT_UP.
REQ-024 WAIT_UP: ext_reset=0 and the timer counts from 0; channel_up high moves to UP.
REQ-025 WAIT_UP: if channel_up is still low when the timer reaches UP_TIMEOUT-1, the block moves to BACKOFF and retry_count increments.
REQ-026 WAIT_UP: channel_up high on the timeout cycle moves to UP with no retry.
REQ-027 UP: ext_reset=0 and link_ok=1.
REQ-028 UP: channel_up low or hard_err high moves to BACKOFF with one retry_count increment, even if both occur in the same cycle.
REQ-029 UP: a window counter runs 0..WINDOW_CYCLES-1 and wraps; a window soft-error counter counts soft_err cycles.
REQ-030 UP: when the window soft-error count, including the current cycle, reaches SOFT_ERR_LIMIT, the block moves to BACKOFF with one retry_count increment.
REQ-031 On the window wrap cycle, the window soft-error counter loads 1 if soft_err is high, else 0.
REQ-032 On entry to UP, both the window counter and the window soft-error counter are zero.
REQ-033 BACKOFF: ext_reset=1 for exactly BACKOFF_CYCLES cycles, then RESET.
REQ-034 retry_count saturates at 255; soft_err_total saturates at 65535.
REQ-035 soft_err_total increments on each UP-state cycle with soft_err high.
REQ-036 clr_counts zeroes retry_count and soft_err_total next cycle; a simultaneous increment is discarded.
REQ-037 clr_counts does not affect state, the timers or the window counters.
REQ-038 hard_err and soft_err are ignored outside UP.

Reset
REQ-039 aresetn low asynchronously sets state=IDLE, ext_reset=1, link_ok=0, all counters and timers=0.
REQ-040 After aresetn deasserts, the first transition occurs no earlier than the first user_clk edge.
REQ-041 aresetn asserted mid-operation in any state aborts immediately; the statistics counters are not retained.

Verification (RESET_CYCLES=4, UP_TIMEOUT=8, BACKOFF_CYCLES=3, SOFT_ERR_LIMIT=3, WINDOW_CYCLES=10)
REQ-042 Scenario 1: enable=1 with channel_up rising 2 cycles into WAIT_UP -> ext_reset high 4 cycles, then state=3 and link_ok=1, retry_count=0.
REQ-043 Scenario 2: channel_up held low -> 8 cycles in WAIT_UP, 3 in BACKOFF, back to RESET, retry_count=1; after 300 retries retry_count=255.
REQ-044 Scenario 3: in UP, hard_err and channel_up fall in the same cycle -> state=4 next cycle, retry_count increments by exactly 1.
REQ-045 Scenario 4: soft_err on UP cycles 2, 5 and 7 -> BACKOFF after cycle 7; soft_err on cycles 8 and 9 then 10 (wrap) -> no retry, window count=1.
REQ-046 Scenario 5: clr_counts on the same cycle as a retry -> retry_count=0; enable dropped in UP -> state=0 and ext_reset=1 next cycle.
REQ-047 Scenario 6: aresetn pulsed low mid-BACKOFF -> all outputs at reset values without a clock edge.
